// File: rtl/bmp_pkg.sv
// Shared constants, state encoding and size helpers for the BMP stream writer.
package bmp_pkg;

  localparam int BMP_HDR_BYTES = 54;
  localparam int DIB_HDR_BYTES = 40;

  // State encoding kept as plain vectors so older tools and dumps decode it.
  typedef logic [2:0] bmp_state_t;
  localparam bmp_state_t ST_IDLE   = 3'd0;
  localparam bmp_state_t ST_HEADER = 3'd1;
  localparam bmp_state_t ST_PIXEL  = 3'd2;
  localparam bmp_state_t ST_PAD    = 3'd3;
  localparam bmp_state_t ST_DONE   = 3'd4;

  // Bytes per stored row: raw pixel bytes rounded up to a 4-byte multiple.
  function automatic int row_bytes(input int width, input int bpp);
    return ((width * (bpp / 8)) + 3) / 4 * 4;
  endfunction

  // Total file size: both headers plus every padded row.
  function automatic int file_bytes(input int width, input int height, input int bpp);
    return BMP_HDR_BYTES + height * row_bytes(width, bpp);
  endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational lookup of the 54-byte BMP + DIB header for a fixed image geometry.
module bmp_header_rom
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 426,
  parameter int BPP    = 24
) (
  input  logic [5:0] idx_i,
  output logic [7:0] byte_o
);

  localparam logic [31:0] FILE_SZ = 32'(file_bytes(WIDTH, HEIGHT, BPP));
  localparam logic [31:0] IMG_SZ  = 32'(HEIGHT * row_bytes(WIDTH, BPP));
  localparam logic [31:0] OFF_SZ  = 32'(BMP_HDR_BYTES);
  localparam logic [31:0] DIB_SZ  = 32'(DIB_HDR_BYTES);
  localparam logic [31:0] W_FLD   = 32'(WIDTH);
  localparam logic [31:0] NEG_H   = 32'(-HEIGHT);
  localparam logic [15:0] BPP_FLD = 16'(BPP);

  // Every multi-byte field starts at an address that is 2 mod 4, so one
  // 32-bit word per group and a fixed lane rotation cover the whole header.
  logic [1:0]  lane_s;
  logic [31:0] word_s;

  assign lane_s = idx_i[1:0] ^ 2'b10;

  // Pick the field word covering this address, then the little-endian lane.
  always_comb begin
    word_s = 32'h0000_0000;
    case (idx_i)
      6'd0, 6'd1:                word_s = 32'h4D42_0000;
      6'd2, 6'd3, 6'd4, 6'd5:    word_s = FILE_SZ;
      6'd10, 6'd11, 6'd12, 6'd13: word_s = OFF_SZ;
      6'd14, 6'd15, 6'd16, 6'd17: word_s = DIB_SZ;
      6'd18, 6'd19, 6'd20, 6'd21: word_s = W_FLD;
      6'd22, 6'd23, 6'd24, 6'd25: word_s = NEG_H;
      6'd26, 6'd27, 6'd28, 6'd29: word_s = {BPP_FLD, 16'h0001};
      6'd34, 6'd35, 6'd36, 6'd37: word_s = IMG_SZ;
      default:                   word_s = 32'h0000_0000;
    endcase
    byte_o = word_s[{lane_s, 3'b000} +: 8];
  end

endmodule

// File: rtl/bmp_stream_writer.sv
// Turns a beat stream of RGB pixels into the byte stream of a top-down BMP file.
module bmp_stream_writer
  import bmp_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 426,
  parameter int PPB    = 2,
  parameter int BPP    = 24
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PPB*24-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int BYTES_PP   = BPP / 8;
  localparam int BEAT_BYTES = PPB * BYTES_PP;
  localparam int PAD        = row_bytes(WIDTH, BPP) - WIDTH * BYTES_PP;
  localparam bit PAD_EN     = (PAD > 0);

  localparam logic [5:0]  HDR_LAST  = 6'(BMP_HDR_BYTES - 1);
  localparam logic [5:0]  BEAT_LAST = 6'(BEAT_BYTES - 1);
  localparam logic [5:0]  PAD_LAST  = 6'(PAD_EN ? PAD - 1 : 0);
  localparam logic [15:0] COL_LAST  = 16'(WIDTH / PPB - 1);
  localparam logic [15:0] ROW_LAST  = 16'(HEIGHT - 1);

  bmp_state_t            state_q, state_d;
  logic [5:0]            byte_idx_q, byte_idx_d;
  logic [15:0]           col_q, col_d;
  logic [15:0]           row_q, row_d;
  logic [PPB*24-1:0]     beat_q, beat_d;
  logic                  beat_full_q, beat_full_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q;
  logic                  frame_done_q;
  logic [15:0]           frame_count_q;

  logic                  in_ready_s, can_load_s, out_accept_s, beat_take_s, final_beat_s;
  logic [7:0]            hdr_byte_s, pix_byte_s;
  logic [PPB*32-1:0]     beat_ext_s;

  assign in_ready_s   = (state_q == ST_PIXEL) & ~beat_full_q;
  assign out_accept_s = out_valid_q & out_ready;
  assign can_load_s   = ~out_valid_q | out_ready;
  assign beat_take_s  = in_valid & in_ready_s;
  assign final_beat_s = (row_q == ROW_LAST) & (col_q == COL_LAST);

  bmp_header_rom #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP(BPP)) u_hdr (
    .idx_i  (byte_idx_q),
    .byte_o (hdr_byte_s)
  );

  // Pick the byte of the held beat addressed by byte_idx (B,G,R then 0x00 fill).
  always_comb begin
    pix_byte_s = 8'h00;
    for (int p = 0; p < PPB; p++) begin
      beat_ext_s[32*p +: 32] = {8'h00, beat_q[24*p +: 24]};
    end
    for (int p = 0; p < PPB; p++) begin
      for (int c = 0; c < BYTES_PP; c++) begin
        if (byte_idx_q == 6'(p * BYTES_PP + c)) begin
          pix_byte_s = beat_ext_s[32*p + 8*c +: 8];
        end else begin
          pix_byte_s = pix_byte_s;
        end
      end
    end
  end

  // Frame sequencing: decides the next output byte and walks header, rows and pad.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    col_d       = col_q;
    row_d       = row_q;
    beat_d      = beat_q;
    beat_full_d = beat_full_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_last_d  = out_last_q & ~out_accept_s;
    out_data_d  = out_data_q;
    frame_err_d = frame_err_q;
    case (state_q)
      ST_IDLE: begin
        // The first header byte is loaded on the start edge itself.
        if (start) begin
          state_d     = ST_HEADER;
          frame_err_d = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = hdr_byte_s;
          out_last_d  = 1'b0;
          byte_idx_d  = 6'd1;
          row_d       = 16'd0;
          col_d       = 16'd0;
        end else begin
          byte_idx_d  = 6'd0;
        end
      end
      ST_HEADER: begin
        if (can_load_s) begin
          out_valid_d = 1'b1;
          out_data_d  = hdr_byte_s;
          out_last_d  = 1'b0;
          if (byte_idx_q == HDR_LAST) begin
            state_d    = ST_PIXEL;
            byte_idx_d = 6'd0;
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
          end
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_PIXEL: begin
        if (beat_take_s) begin
          beat_d      = in_data;
          beat_full_d = 1'b1;
          if (in_last != final_beat_s) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = frame_err_q;
          end
        end else if (beat_full_q && can_load_s) begin
          out_valid_d = 1'b1;
          out_data_d  = pix_byte_s;
          out_last_d  = 1'b0;
          if (byte_idx_q == BEAT_LAST) begin
            byte_idx_d  = 6'd0;
            beat_full_d = 1'b0;
            if (col_q == COL_LAST) begin
              col_d = 16'd0;
              if (PAD_EN) begin
                state_d = ST_PAD;
              end else if (row_q == ROW_LAST) begin
                state_d    = ST_DONE;
                out_last_d = 1'b1;
              end else begin
                row_d = row_q + 16'd1;
              end
            end else begin
              col_d = col_q + 16'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
          end
        end else begin
          state_d = ST_PIXEL;
        end
      end
      ST_PAD: begin
        if (can_load_s) begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          out_last_d  = 1'b0;
          if (byte_idx_q == PAD_LAST) begin
            byte_idx_d = 6'd0;
            if (row_q == ROW_LAST) begin
              state_d    = ST_DONE;
              out_last_d = 1'b1;
            end else begin
              state_d = ST_PIXEL;
              row_d   = row_q + 16'd1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
          end
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_DONE: begin
        // Stay until the sink has taken the final byte.
        if (out_accept_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and FSM registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      byte_idx_q  <= 6'd0;
      col_q       <= 16'd0;
      row_q       <= 16'd0;
      beat_q      <= '0;
      beat_full_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      beat_q      <= beat_d;
      beat_full_q <= beat_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Status: busy tracks the next state, completion pulses after the final byte is taken.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_q == ST_DONE) & out_accept_s;
      if ((state_q == ST_DONE) && out_accept_s) begin
        frame_count_q <= frame_count_q + 16'd1;
      end else begin
        frame_count_q <= frame_count_q;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench: instance 0 is 2x2 PPB=2 24bpp, instance 1 is 4x1 PPB=1 32bpp.
module tb_bmp_stream_writer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start_s     [2];
  logic        in_valid_s  [2];
  logic        in_last_s   [2];
  logic        out_ready_s [2];
  logic [47:0] in_data_a;
  logic [23:0] in_data_b;
  logic        in_ready_s   [2];
  logic        out_valid_s  [2];
  logic [7:0]  out_data_s   [2];
  logic        out_last_s   [2];
  logic        busy_s       [2];
  logic        frame_done_s [2];
  logic        frame_err_s  [2];
  logic [15:0] frame_count_s[2];

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  got [70];
  logic        got_last [70];
  logic [7:0]  exp_a [70];
  logic [7:0]  exp_b [70];
  logic [47:0] beat_tab [2][4];

  always #5 HCLK = ~HCLK;

  bmp_stream_writer #(.WIDTH(2), .HEIGHT(2), .PPB(2), .BPP(24)) u_dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .in_data(in_data_a), .in_last(in_last_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .out_data(out_data_s[0]), .out_last(out_last_s[0]),
    .busy(busy_s[0]), .frame_done(frame_done_s[0]), .frame_err(frame_err_s[0]), .frame_count(frame_count_s[0])
  );

  bmp_stream_writer #(.WIDTH(4), .HEIGHT(1), .PPB(1), .BPP(32)) u_dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .in_data(in_data_b), .in_last(in_last_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .out_data(out_data_s[1]), .out_last(out_last_s[1]),
    .busy(busy_s[1]), .frame_done(frame_done_s[1]), .frame_err(frame_err_s[1]), .frame_count(frame_count_s[1])
  );

  // Drive one frame into instance sel and collect its bytes; optional abort/restart points.
  task automatic run_frame(input int sel, input bit rnd, input int last_beat, input int abort_at,
                           input int restart_at, output int nbytes, output int pulses);
    int n, beat, nb;
    bit stalled, restarted, done;
    logic [7:0] held;
    logic rdy;
    n = 0; beat = 0; stalled = 0; restarted = 0; done = 0; pulses = 0; held = 8'h00;
    nb = (sel == 0) ? 2 : 4;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge HCLK);
      if (abort_at >= 0 && n == abort_at) begin
        HRESETn = 1'b0;
        in_valid_s[sel] = 1'b0;
        start_s[sel] = 1'b0;
        done = 1;
      end else begin
        if (cyc == 0) start_s[sel] = 1'b1;
        else if (restart_at >= 0 && n >= restart_at && !restarted) begin
          start_s[sel] = 1'b1;
          restarted = 1;
        end else start_s[sel] = 1'b0;
        if (cyc == 1) begin
          checks++;
          if (out_valid_s[sel] !== 1'b1 || out_data_s[sel] !== 8'h42) begin
            failures++;
            $display("FAIL first_byte: got valid=%b data=%h, expected valid=1 data=42", out_valid_s[sel], out_data_s[sel]);
          end
          checks++;
          if (busy_s[sel] !== 1'b1 || frame_err_s[sel] !== 1'b0) begin
            failures++;
            $display("FAIL start_status: got busy=%b err=%b, expected busy=1 err=0", busy_s[sel], frame_err_s[sel]);
          end
        end
        if (stalled) begin
          checks++;
          if (out_valid_s[sel] !== 1'b1 || out_data_s[sel] !== held) begin
            failures++;
            $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h", out_valid_s[sel], out_data_s[sel], held);
          end
        end
        if (beat < nb) begin
          in_valid_s[sel] = 1'b1;
          in_last_s[sel]  = (beat == last_beat);
          if (sel == 0) in_data_a = beat_tab[0][beat];
          else in_data_b = beat_tab[1][beat][23:0];
          if (in_ready_s[sel] === 1'b1) beat++;
        end else begin
          in_valid_s[sel] = 1'b0;
          in_last_s[sel]  = 1'b0;
        end
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready_s[sel] = rdy;
        if (out_valid_s[sel] === 1'b1 && rdy) begin
          got[n] = out_data_s[sel];
          got_last[n] = out_last_s[sel];
          n++;
          stalled = 0;
          if (n == 70) done = 1;
        end else begin
          stalled = (out_valid_s[sel] === 1'b1);
          held = out_data_s[sel];
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got %0d bytes, expected 70 within budget", n);
    end
    if (abort_at < 0) begin
      @(negedge HCLK);
      start_s[sel] = 1'b0; in_valid_s[sel] = 1'b0; in_last_s[sel] = 1'b0; out_ready_s[sel] = 1'b1;
      if (frame_done_s[sel] === 1'b1) pulses++;
      repeat (3) begin
        @(negedge HCLK);
        if (frame_done_s[sel] === 1'b1) pulses++;
      end
    end
    nbytes = n;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge HCLK);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (in_ready_s[s] !== 1'b0 || out_valid_s[s] !== 1'b0 || out_data_s[s] !== 8'h00 || out_last_s[s] !== 1'b0 ||
          busy_s[s] !== 1'b0 || frame_done_s[s] !== 1'b0 || frame_err_s[s] !== 1'b0 || frame_count_s[s] !== 16'd0) begin
        failures++;
        $display("FAIL reset_values: inst %0d got rdy=%b v=%b d=%h l=%b busy=%b done=%b err=%b cnt=%0d, expected all 0",
                 s, in_ready_s[s], out_valid_s[s], out_data_s[s], out_last_s[s], busy_s[s], frame_done_s[s], frame_err_s[s], frame_count_s[s]);
      end
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, expected 0 0", out_valid_s[0], busy_s[0]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int n, p;
    run_frame(0, 1'b0, 1, 30, -1, n, p);
    checks++;
    if (n !== 30) begin
      failures++;
      $display("FAIL abort_point: got %0d bytes, expected 30", n);
    end
    @(negedge HCLK);
    checks++;
    if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || frame_count_s[0] !== 16'd0 || in_ready_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b busy=%b cnt=%0d rdy=%b, expected 0 0 0 0",
               out_valid_s[0], busy_s[0], frame_count_s[0], in_ready_s[0]);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_basic_frame;
    int n, p;
    run_frame(0, 1'b0, 1, -1, -1, n, p);
    checks++;
    if (n !== 70) begin failures++; $display("FAIL basic_len: got %0d, expected 70", n); end
    for (int i = 0; i < 70; i++) begin
      checks++;
      if (got[i] !== exp_a[i] || got_last[i] !== (i == 69)) begin
        failures++;
        $display("FAIL basic_byte[%0d]: got %h last=%b, expected %h last=%b", i, got[i], got_last[i], exp_a[i], (i == 69));
      end
    end
    checks++;
    if (p !== 1 || frame_count_s[0] !== 16'd1 || frame_err_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_status: got pulses=%0d cnt=%0d err=%b busy=%b, expected 1 1 0 0", p, frame_count_s[0], frame_err_s[0], busy_s[0]);
    end
  endtask

  task automatic test_backpressure;
    int n, p;
    run_frame(0, 1'b1, 1, -1, -1, n, p);
    checks++;
    if (n !== 70) begin failures++; $display("FAIL bp_len: got %0d, expected 70", n); end
    for (int i = 0; i < 70; i++) begin
      checks++;
      if (got[i] !== exp_a[i] || got_last[i] !== (i == 69)) begin
        failures++;
        $display("FAIL bp_byte[%0d]: got %h last=%b, expected %h last=%b", i, got[i], got_last[i], exp_a[i], (i == 69));
      end
    end
    checks++;
    if (p !== 1 || frame_count_s[0] !== 16'd2) begin
      failures++;
      $display("FAIL bp_status: got pulses=%0d cnt=%0d, expected 1 2", p, frame_count_s[0]);
    end
  endtask

  task automatic test_early_last;
    int n, p;
    run_frame(0, 1'b0, 0, -1, -1, n, p);
    checks++;
    if (n !== 70 || frame_count_s[0] !== 16'd3) begin
      failures++;
      $display("FAIL early_len: got %0d bytes cnt=%0d, expected 70 3", n, frame_count_s[0]);
    end
    for (int i = 54; i < 70; i++) begin
      checks++;
      if (got[i] !== exp_a[i]) begin
        failures++;
        $display("FAIL early_byte[%0d]: got %h, expected %h", i, got[i], exp_a[i]);
      end
    end
    checks++;
    if (frame_err_s[0] !== 1'b1) begin failures++; $display("FAIL early_err: got %b, expected 1", frame_err_s[0]); end
    repeat (5) @(negedge HCLK);
    checks++;
    if (frame_err_s[0] !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b, expected 1", frame_err_s[0]); end
  endtask

  task automatic test_start_while_busy;
    int n, p;
    run_frame(0, 1'b0, 1, -1, 10, n, p);
    checks++;
    if (n !== 70 || p !== 1 || frame_err_s[0] !== 1'b0) begin
      failures++;
      $display("FAIL busy_start: got bytes=%0d pulses=%0d err=%b, expected 70 1 0", n, p, frame_err_s[0]);
    end
    repeat (6) begin
      @(negedge HCLK);
      checks++;
      if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
        failures++;
        $display("FAIL no_queued_start: got valid=%b busy=%b, expected 0 0", out_valid_s[0], busy_s[0]);
      end
    end
    checks++;
    if (frame_count_s[0] !== 16'd4) begin failures++; $display("FAIL busy_count: got %0d, expected 4", frame_count_s[0]); end
  endtask

  task automatic test_bpp32;
    int n, p;
    run_frame(1, 1'b0, 3, -1, -1, n, p);
    checks++;
    if (n !== 70) begin failures++; $display("FAIL bpp32_len: got %0d, expected 70", n); end
    for (int i = 0; i < 70; i++) begin
      checks++;
      if (got[i] !== exp_b[i] || got_last[i] !== (i == 69)) begin
        failures++;
        $display("FAIL bpp32_byte[%0d]: got %h last=%b, expected %h last=%b", i, got[i], got_last[i], exp_b[i], (i == 69));
      end
    end
    checks++;
    if (p !== 1 || frame_count_s[1] !== 16'd1 || frame_err_s[1] !== 1'b0) begin
      failures++;
      $display("FAIL bpp32_status: got pulses=%0d cnt=%0d err=%b, expected 1 1 0", p, frame_count_s[1], frame_err_s[1]);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_s[s] = 1'b0; in_valid_s[s] = 1'b0; in_last_s[s] = 1'b0; out_ready_s[s] = 1'b1;
    end
    in_data_a = 48'h0; in_data_b = 24'h0;
    beat_tab[0][0] = 48'h405060_102030; beat_tab[0][1] = 48'hD4E5F6_A1B2C3;
    beat_tab[0][2] = 48'h0; beat_tab[0][3] = 48'h0;
    beat_tab[1][0] = 48'h000000_112233; beat_tab[1][1] = 48'h000000_445566;
    beat_tab[1][2] = 48'h000000_778899; beat_tab[1][3] = 48'h000000_AABBCC;
    exp_a = '{8'h42, 8'h4D, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00,
              8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF,
              8'hFF, 8'hFF, 8'h01, 8'h00, 8'h18, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h30, 8'h20, 8'h10, 8'h60, 8'h50, 8'h40, 8'h00, 8'h00,
              8'hC3, 8'hB2, 8'hA1, 8'hF6, 8'hE5, 8'hD4, 8'h00, 8'h00};
    exp_b = '{8'h42, 8'h4D, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h36, 8'h00, 8'h00, 8'h00, 8'h28, 8'h00,
              8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF,
              8'hFF, 8'hFF, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h33, 8'h22, 8'h11, 8'h00, 8'h66, 8'h55, 8'h44, 8'h00,
              8'h99, 8'h88, 8'h77, 8'h00, 8'hCC, 8'hBB, 8'hAA, 8'h00};
    test_reset();
    test_reset_mid_frame();
    test_basic_frame();
    test_backpressure();
    test_early_last();
    test_start_while_busy();
    test_bpp32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
